// File: rtl/bayer_pkg.sv
// rtl/bayer_pkg.sv - shared widths, luma weights and the quad weighted-sum helper
package bayer_pkg;

    localparam int RAW_W   = 12;
    localparam int GRAY_W  = 8;
    localparam int SUM_W   = 20;
    localparam int COORD_W = 10;

    // Luma weights scaled so that they total 256; the sum then fits SUM_W bits.
    localparam int W_R = 77;
    localparam int W_G = 75;
    localparam int W_B = 29;

    // Weighted quad sum scaled down to the 8-bit gray value (sum / 2^12).
    function automatic logic [GRAY_W-1:0] quad_to_gray(
        input logic [RAW_W-1:0] r,
        input logic [RAW_W-1:0] g1,
        input logic [RAW_W-1:0] g2,
        input logic [RAW_W-1:0] b
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(W_R) * SUM_W'(r)
            + SUM_W'(W_G) * (SUM_W'(g1) + SUM_W'(g2))
            + SUM_W'(W_B) * SUM_W'(b);
        return GRAY_W'(sum >> (SUM_W - GRAY_W));
    endfunction

endpackage

// File: rtl/bayer_line_buf.sv
// rtl/bayer_line_buf.sv - one raw line of storage with registered read
module bayer_line_buf
    import bayer_pkg::*;
#(
    parameter int DEPTH = 1280,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [RAW_W-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [RAW_W-1:0] rd_data_o
);

    logic [RAW_W-1:0] mem_q [DEPTH];
    logic [RAW_W-1:0] rd_data_q;

    // Write port plus registered read; the read data holds until the next read.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bayer_to_gray.sv
// rtl/bayer_to_gray.sv - GR/BG Bayer quads to half-resolution 8-bit gray stream
module bayer_to_gray
    import bayer_pkg::*;
#(
    parameter int IN_WIDTH  = 1280,
    parameter int IN_HEIGHT = 960
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [RAW_W-1:0]   iRaw,
    input  logic               iDVAL,
    input  logic               iFVAL,
    output logic [GRAY_W-1:0]  oGray,
    output logic               oDVAL,
    output logic [COORD_W-1:0] oCol,
    output logic [COORD_W-1:0] oRow
);

    localparam int COL_W = $clog2(IN_WIDTH);
    localparam int ROW_W = $clog2(IN_HEIGHT);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic accept;
    logic odd_row;
    logic odd_col;
    logic quad_done;

    logic [RAW_W-1:0] lb_rd_data;
    logic [RAW_W-1:0] b_q;

    logic               s1_valid_q;
    logic [RAW_W-1:0]   s1_g1_q;
    logic [RAW_W-1:0]   s1_g2_q;
    logic [RAW_W-1:0]   s1_b_q;
    logic [COORD_W-1:0] s1_col_q;
    logic [COORD_W-1:0] s1_row_q;

    assign accept    = iFVAL & iDVAL;
    assign odd_row   = row_q[0];
    assign odd_col   = col_q[0];
    assign quad_done = accept & odd_row & odd_col;

    // Raw position of the next accepted pixel; pinned to (0,0) outside a frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (!iFVAL) begin
            col_d = '0;
            row_d = '0;
        end else if (iDVAL) begin
            if (col_q == COL_W'(IN_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IN_HEIGHT - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Counter registers; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Even rows fill the buffer. On odd rows the even-col cycle reads G1 and the
    // odd-col cycle reads R; G1 is taken off the read port before it is replaced.
    bayer_line_buf #(
        .DEPTH (IN_WIDTH)
    ) u_line_buf (
        .clk_i     (clk),
        .wr_en_i   (accept & ~odd_row),
        .wr_addr_i (col_q),
        .wr_data_i (iRaw),
        .rd_en_i   (accept & odd_row),
        .rd_addr_i (col_q),
        .rd_data_o (lb_rd_data)
    );

    // Bottom-left pixel of the quad, held until the odd-col pixel completes it.
    always_ff @(posedge clk) begin
        if (accept && odd_row && !odd_col) begin
            b_q <= iRaw;
        end
    end

    // Stage 1: register the quad (R arrives from the line buffer read port).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= quad_done;
        end
        if (quad_done) begin
            s1_g1_q  <= lb_rd_data;
            s1_g2_q  <= iRaw;
            s1_b_q   <= b_q;
            s1_col_q <= COORD_W'(col_q >> 1);
            s1_row_q <= COORD_W'(row_q >> 1);
        end
    end

    // Stage 2: weighted sum and output registers; values hold between pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oGray <= '0;
            oDVAL <= 1'b0;
            oCol  <= '0;
            oRow  <= '0;
        end else begin
            oDVAL <= s1_valid_q;
            if (s1_valid_q) begin
                oGray <= quad_to_gray(lb_rd_data, s1_g1_q, s1_g2_q, s1_b_q);
                oCol  <= s1_col_q;
                oRow  <= s1_row_q;
            end
        end
    end

endmodule

// File: tb/tb_bayer_to_gray.sv
// tb/tb_bayer_to_gray.sv - directed and table-driven checks of bayer_to_gray
module tb_bayer_to_gray;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int NQ = (W / 2) * (H / 2);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] iRaw = '0;
    logic        iDVAL = 1'b0;
    logic        iFVAL = 1'b0;
    logic [7:0]  oGray;
    logic        oDVAL;
    logic [9:0]  oCol;
    logic [9:0]  oRow;

    bayer_to_gray #(
        .IN_WIDTH  (W),
        .IN_HEIGHT (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iRaw  (iRaw),
        .iDVAL (iDVAL),
        .iFVAL (iFVAL),
        .oGray (oGray),
        .oDVAL (oDVAL),
        .oCol  (oCol),
        .oRow  (oRow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] r;
        logic [11:0] g1;
        logic [11:0] g2;
        logic [11:0] b;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        logic [7:0] gray;
        int         col;
        int         row;
        int         cyc;
    } out_t;

    vec_t quads [NQ];
    out_t exp_q [$];
    out_t got_q [$];

    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        if (oDVAL) got_q.push_back('{oGray, int'(oCol), int'(oRow), cyc});
    end

    task automatic check(input string name, input int idx, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s[%0d] got %0d want %0d", name, idx, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pix(input int r, input int c);
        int q;
        q = (r / 2) * (W / 2) + c / 2;
        case ({r[0], c[0]})
            2'b00:   return quads[q].g1;
            2'b01:   return quads[q].r;
            2'b10:   return quads[q].b;
            default: return quads[q].g2;
        endcase
    endfunction

    task automatic fill_all(input logic [11:0] v, input logic [7:0] e);
        for (int i = 0; i < NQ; i++) quads[i] = '{v, v, v, v, e};
    endtask

    // Sends the first npix raw pixels of the current quad frame.
    task automatic drive_frame(input int npix, input bit gaps, input bit keep_open);
        iFVAL = 1'b1;
        for (int p = 0; p < npix; p++) begin
            int r;
            int c;
            r = p / W;
            c = p % W;
            if (gaps) begin
                int g;
                g = $urandom_range(1, 3);
                iDVAL = 1'b0;
                repeat (g) step();
            end
            iRaw  = pix(r, c);
            iDVAL = 1'b1;
            if ((r % 2 == 1) && (c % 2 == 1))
                exp_q.push_back('{quads[(r / 2) * (W / 2) + c / 2].exp, c / 2, r / 2, cyc + 2});
            step();
        end
        iDVAL = 1'b0;
        if (!keep_open) begin
            iFVAL = 1'b0;
            repeat (6) step();
        end
    endtask

    task automatic check_outputs(input string name);
        int n;
        check({name, "_count"}, 0, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_gray"}, i, int'(got_q[i].gray), int'(exp_q[i].gray));
            check({name, "_col"},  i, got_q[i].col, exp_q[i].col);
            check({name, "_row"},  i, got_q[i].row, exp_q[i].row);
            check({name, "_cyc"},  i, got_q[i].cyc, exp_q[i].cyc);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t tbl [NQ];
        tbl[0] = '{12'd4095, 12'd0,    12'd0,    12'd0,    8'd76};
        tbl[1] = '{12'd0,    12'd4095, 12'd4095, 12'd0,    8'd149};
        tbl[2] = '{12'd0,    12'd0,    12'd0,    12'd4095, 8'd28};
        tbl[3] = '{12'd0,    12'd0,    12'd0,    12'd0,    8'd0};
        tbl[4] = '{12'd4095, 12'd4095, 12'd4095, 12'd4095, 8'd255};
        tbl[5] = '{12'd1000, 12'd2000, 12'd3000, 12'd4000, 8'd138};
        tbl[6] = '{12'd4095, 12'd0,    12'd0,    12'd4095, 8'd105};
        tbl[7] = '{12'd16,   12'd0,    12'd0,    12'd0,    8'd0};

        // Reset state
        repeat (2) step();
        check("rst_dval", 0, int'(oDVAL), 0);
        check("rst_gray", 0, int'(oGray), 0);
        check("rst_col",  0, int'(oCol),  0);
        check("rst_row",  0, int'(oRow),  0);
        rst_n = 1'b1;
        repeat (2) step();

        // All-4095 frame, continuous valid
        fill_all(12'd4095, 8'd255);
        drive_frame(W * H, 1'b0, 1'b0);
        check_outputs("full");

        // Table of single-channel and mixed quads
        for (int i = 0; i < NQ; i++) quads[i] = tbl[i];
        drive_frame(W * H, 1'b0, 1'b0);
        check_outputs("table");

        // Gaps of 1-3 cycles in valid
        fill_all(12'd4095, 8'd255);
        drive_frame(W * H, 1'b1, 1'b0);
        check_outputs("gaps");

        // Short frame: only completed quads emerge, trailing half quad dropped
        drive_frame(W + 5, 1'b0, 1'b0);
        check_outputs("short");
        drive_frame(W * H, 1'b0, 1'b0);
        check_outputs("after_short");

        // Reset with a quad in the pipeline
        drive_frame(W + 2, 1'b0, 1'b1);
        rst_n = 1'b0;
        step();
        check("midrst_dval", 0, int'(oDVAL), 0);
        check("midrst_gray", 0, int'(oGray), 0);
        check("midrst_col",  0, int'(oCol),  0);
        check("midrst_row",  0, int'(oRow),  0);
        rst_n = 1'b1;
        iFVAL = 1'b0;
        repeat (4) step();
        check("midrst_spurious", 0, got_q.size(), 0);
        got_q.delete();
        exp_q.delete();
        drive_frame(W * H, 1'b0, 1'b0);
        check_outputs("after_rst");

        // Random data against the weighted-sum reference
        for (int i = 0; i < NQ; i++) begin
            logic [19:0] s;
            quads[i].r  = 12'($urandom);
            quads[i].g1 = 12'($urandom);
            quads[i].g2 = 12'($urandom);
            quads[i].b  = 12'($urandom);
            s = 20'd77 * quads[i].r + 20'd75 * quads[i].g1
              + 20'd75 * quads[i].g2 + 20'd29 * quads[i].b;
            quads[i].exp = s[19:12];
        end
        drive_frame(W * H, 1'b1, 1'b0);
        check_outputs("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
